// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned restoring divider
//
// Purpose: answers divide requests from the execute stage. A request is
// accepted in FREE; the divider then runs 32 shift-subtract steps, applies
// the sign fix and presents {remainder, quotient} with ready held until the
// requester drops start. Divide by zero returns 0 after one extra edge.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   div_start_i    request, held high until div_ready_o is seen
//   div_signed_i   1 = signed (DIV), 0 = unsigned (DIVU), sampled at start
//   div_annul_i    cancel an in-flight divide
//   div_opdata1_i  dividend, sampled at start
//   div_opdata2_i  divisor, sampled at start
//   div_result_o   {remainder[63:32], quotient[31:0]}
//   div_ready_o    result valid
//   div_busy_o     high while in BYZERO or ON
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start_i,
  input  logic        div_signed_i,
  input  logic        div_annul_i,
  input  logic [31:0] div_opdata1_i,
  input  logic [31:0] div_opdata2_i,
  output logic [63:0] div_result_o,
  output logic        div_ready_o,
  output logic        div_busy_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  // Operand prep: magnitudes and result signs
  logic        sign1, sign2;
  logic [31:0] abs1, abs2;

  assign sign1 = div_signed_i & div_opdata1_i[31];
  assign sign2 = div_signed_i & div_opdata2_i[31];
  assign abs1  = sign1 ? (~div_opdata1_i + 32'd1) : div_opdata1_i;
  assign abs2  = sign2 ? (~div_opdata2_i + 32'd1) : div_opdata2_i;

  // Working register: [64:32] partial remainder, [31:0] dividend bits still
  // to be consumed from the top while quotient bits fill in from the bottom.
  // The remainder field is 33 bits because a shifted remainder can reach
  // 2*divisor-1 before the compare.
  logic [64:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [64:0] step_res;

  assign shifted  = work_q << 1;
  assign ge       = shifted[64:32] >= {1'b0, divisor_q};
  assign diff     = shifted[64:32] - {1'b0, divisor_q};
  assign step_res = ge ? {diff, shifted[31:1], 1'b1} : shifted;

  // Sign fix on the finished magnitudes
  logic [31:0] q_raw, r_raw, q_fix, r_fix;

  assign q_raw = work_q[31:0];
  assign r_raw = work_q[63:32];
  assign q_fix = qneg_q ? (~q_raw + 32'd1) : q_raw;
  assign r_fix = rneg_q ? (~r_raw + 32'd1) : r_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (div_start_i && !div_annul_i) begin
          if (div_opdata2_i == 32'h0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = 6'd0;
            work_d    = {33'h0, abs1};
            divisor_d = abs2;
            qneg_d    = sign1 ^ sign2;
            rneg_d    = sign1;
          end
        end
      end

      S_BYZERO: begin
        if (div_annul_i || !div_start_i) begin
          state_d  = S_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_END;
          result_d = 64'h0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        // Cancel takes priority even on the sign-fix edge
        if (div_annul_i || !div_start_i) begin
          state_d  = S_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = S_END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end else begin
          work_d = step_res;
          cnt_d  = cnt_q + 6'd1;
        end
      end

      S_END: begin
        ready_d = 1'b1;
        if (!div_start_i) begin
          state_d  = S_FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = S_FREE;
        result_d = 64'h0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'h0;
      divisor_q <= 32'h0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign div_result_o = result_q;
  assign div_ready_o  = ready_q;
  assign div_busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start_i;
  logic        div_signed_i;
  logic        div_annul_i;
  logic [31:0] div_opdata1_i;
  logic [31:0] div_opdata2_i;
  logic [63:0] div_result_o;
  logic        div_ready_o;
  logic        div_busy_o;

  int checks = 0;
  int failures = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .div_start_i  (div_start_i),
    .div_signed_i (div_signed_i),
    .div_annul_i  (div_annul_i),
    .div_opdata1_i(div_opdata1_i),
    .div_opdata2_i(div_opdata2_i),
    .div_result_o (div_result_o),
    .div_ready_o  (div_ready_o),
    .div_busy_o   (div_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder
  // takes the dividend's sign; divide by zero yields 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp);
    int edges, busy_n, exp_lat, exp_busy;
    bit got, early_res;
    logic [63:0] res;
    exp_lat  = (b == 32'h0) ? 2 : 34;
    exp_busy = (b == 32'h0) ? 1 : 33;
    @(negedge clk);
    div_start_i   = 1'b1;
    div_annul_i   = 1'b0;
    div_signed_i  = sgn;
    div_opdata1_i = a;
    div_opdata2_i = b;
    edges = 0; busy_n = 0; got = 0; early_res = 0;
    while (edges < 100 && !got) begin
      @(posedge clk); #1;
      edges++;
      if (div_busy_o) busy_n++;
      if (div_ready_o) got = 1;
      else if (div_result_o != 64'h0) early_res = 1;
      // operands must have been captured at acceptance only
      div_opdata1_i = $urandom;
      div_opdata2_i = $urandom;
      div_signed_i  = $urandom_range(0, 1);
    end
    res = div_result_o;
    check("ready_seen", 64'(got), 64'd1);
    check("latency", 64'(edges), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check("result_zero_before_ready", 64'(early_res), 64'd0);
    check("result", res, exp);
    repeat (2) @(posedge clk);
    #1;
    check("ready_hold", 64'(div_ready_o), 64'd1);
    check("result_hold", div_result_o, exp);
    check("no_retrigger_busy", 64'(div_busy_o), 64'd0);
    @(negedge clk);
    div_start_i = 1'b0;
    @(posedge clk); #1;
    check("ready_drop", 64'(div_ready_o), 64'd0);
    check("result_drop", div_result_o, 64'h0);
  endtask

  initial begin
    rst = 1'b1;
    div_start_i = 1'b0;
    div_signed_i = 1'b0;
    div_annul_i = 1'b0;
    div_opdata1_i = 32'h0;
    div_opdata2_i = 32'h0;

    vecs[0] = '{32'd7,        32'd2,        1'b1, {32'h1,        32'h3}};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2] = '{32'hFFFFFFF9, 32'd2,        1'b0, {32'h1,        32'h7FFFFFFC}};
    vecs[3] = '{32'hFFFFFFFF, 32'h10,       1'b0, {32'hF,        32'h0FFFFFFF}};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0,        32'h80000000}};
    vecs[5] = '{32'd5,        32'd0,        1'b1, 64'h0};
    vecs[6] = '{32'd7,        32'hFFFFFFFE, 1'b1, {32'h1,        32'hFFFFFFFD}};
    vecs[7] = '{32'd0,        32'd5,        1'b0, 64'h0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(div_ready_o), 64'd0);
    check("reset_busy", 64'(div_busy_o), 64'd0);
    check("reset_result", div_result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back to back
    for (int i = 0; i < 8; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);

    // Start and annul together in FREE: annul wins
    begin
      bit bad;
      bad = 0;
      @(negedge clk);
      div_start_i = 1'b1; div_annul_i = 1'b1;
      div_opdata1_i = 32'd9; div_opdata2_i = 32'd3;
      repeat (3) begin
        @(posedge clk); #1;
        if (div_busy_o || div_ready_o) bad = 1;
      end
      check("start_annul_free", 64'(bad), 64'd0);
      @(negedge clk);
      div_start_i = 1'b0; div_annul_i = 1'b0;
    end

    // Annul at iteration 10, then immediately start 100 / 7
    begin
      bit rdy;
      rdy = 0;
      @(negedge clk);
      div_start_i = 1'b1; div_signed_i = 1'b0;
      div_opdata1_i = 32'd1000; div_opdata2_i = 32'd3;
      repeat (11) begin
        @(posedge clk); #1;
        if (div_ready_o) rdy = 1;
      end
      @(negedge clk);
      div_annul_i = 1'b1;
      @(posedge clk); #1;
      if (div_ready_o) rdy = 1;
      check("annul_no_ready", 64'(rdy), 64'd0);
      check("annul_busy", 64'(div_busy_o), 64'd0);
      check("annul_result", div_result_o, 64'h0);
      run_div(32'd100, 32'd7, 1'b1, {32'h2, 32'hE});
    end

    // Start dropped mid-ON and in BYZERO cancels
    @(negedge clk);
    div_start_i = 1'b1; div_opdata1_i = 32'd50; div_opdata2_i = 32'd5;
    repeat (6) @(posedge clk);
    @(negedge clk);
    div_start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_on_busy", 64'(div_busy_o), 64'd0);
    check("drop_on_ready", 64'(div_ready_o), 64'd0);
    @(negedge clk);
    div_start_i = 1'b1; div_opdata2_i = 32'd0;
    @(posedge clk);
    @(negedge clk);
    div_start_i = 1'b0;
    @(posedge clk); #1;
    check("drop_byzero_busy", 64'(div_busy_o), 64'd0);
    check("drop_byzero_ready", 64'(div_ready_o), 64'd0);

    // Reset at iteration 20, then a full-latency divide
    @(negedge clk);
    div_start_i = 1'b1; div_signed_i = 1'b1;
    div_opdata1_i = 32'hFFFF0000; div_opdata2_i = 32'd33;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", 64'(div_busy_o), 64'd0);
    check("rst_mid_ready", 64'(div_ready_o), 64'd0);
    check("rst_mid_result", div_result_o, 64'h0);
    @(negedge clk);
    rst = 1'b0; div_start_i = 1'b0;
    @(posedge clk);
    run_div(32'd123456, 32'hFFFFFFF5, 1'b1, model(32'd123456, 32'hFFFFFFF5, 1'b1));

    // Randomized against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic sgn;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        default: ;
      endcase
      sgn = $urandom_range(0, 1);
      run_div(a, b, sgn, model(a, b, sgn));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
